// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES round-subkey generator fed by PC-1.
// Loads C/D from the PC-1 output, then on each consumer handshake rotates
// C and D (left for encrypt, right for decrypt) and presents PC-2(C||D)
// as the next 48-bit round subkey. Outputs depend only on registered
// state, so subkey_ready never reaches an output combinationally.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:56] pc1_key,
    input  logic        decrypt,
    input  logic        start,
    output logic        busy,
    output logic [1:48] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:28] c_q, c_d;
    logic [1:28] d_q, d_d;
    logic [3:0]  n_q, n_d;      // issue counter: subkeys already handed over
    logic        dec_q, dec_d;  // direction captured at start
    logic        done_q, done_d;
    logic        handshake;
    logic        shift_two;
    logic [1:48] pc2_out;

    // 28-bit rotate toward bit 1 (DES "left shift") by one or two places.
    function automatic logic [1:28] rot_left(input logic [1:28] x, input logic by_two);
        return by_two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    // 28-bit rotate toward bit 28 by one or two places (decrypt direction).
    function automatic logic [1:28] rot_right(input logic [1:28] x, input logic by_two);
        return by_two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

    // PC-2: selects 48 of the 56 C||D bits; indices are DES bit numbers.
    function automatic logic [1:48] pc2(input logic [1:56] cd);
        return {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
                cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
                cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
                cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
                cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
                cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
                cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
                cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
    endfunction

    assign handshake = (state_q == RUN) && subkey_ready;

    // Handshake n rotates by shift[n+2] when encrypting and by shift[16-n]
    // when decrypting. Both land on a one-place shift exactly at n = 0, 7,
    // 14 and 15. The encrypt entry at n = 15 uses shift[1], so the total
    // over a run is 28 and C/D finish back at their loaded values.
    assign shift_two = !((n_q == 4'd0) || (n_q == 4'd7) ||
                         (n_q == 4'd14) || (n_q == 4'd15));

    assign pc2_out = pc2({c_q, d_q});

    // Registered-state-only outputs; subkey is zeroed when not valid.
    assign busy         = (state_q == RUN);
    assign subkey_valid = (state_q == RUN);
    assign subkey       = (state_q == RUN) ? pc2_out : '0;
    assign round        = dec_q ? (4'd15 - n_q) : n_q;
    assign done         = done_q;

    // Next-state logic: load on start in IDLE, rotate and count on handshake in RUN.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        n_d     = n_q;
        dec_d   = dec_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Encrypt presents K1, so the load already applies shift[1] = 1.
                    // Decrypt presents K16, whose C16/D16 equal C0/D0.
                    if (decrypt) begin
                        c_d = pc1_key[1:28];
                        d_d = pc1_key[29:56];
                    end else begin
                        c_d = rot_left(pc1_key[1:28], 1'b0);
                        d_d = rot_left(pc1_key[29:56], 1'b0);
                    end
                    dec_d   = decrypt;
                    n_d     = 4'd0;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (handshake) begin
                    if (dec_q) begin
                        c_d = rot_right(c_q, shift_two);
                        d_d = rot_right(d_q, shift_two);
                    end else begin
                        c_d = rot_left(c_q, shift_two);
                        d_d = rot_left(d_q, shift_two);
                    end
                    n_d = n_q + 4'd1;
                    if (n_q == 4'd15) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            n_q     <= 4'd0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            n_q     <= n_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: randomized keys, directions and
// backpressure, compared against a textbook DES key-schedule model.
module tb_des_key_schedule;

    logic        clk;
    logic        rst;
    logic [1:56] pc1_key;
    logic        decrypt;
    logic        start;
    logic        busy;
    logic [1:48] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round;
    logic        done;

    int tests_run;
    int tests_failed;

    // Reference model results
    logic [47:0] exp_keys[1:16];
    logic [27:0] exp_c0, exp_d0;

    // Collector results
    logic [47:0] obs_key[16];
    logic [3:0]  obs_round[16];
    logic [47:0] enc_obs[16];
    int          obs_n, stall_bad, done_early, busy_bad, cycles;
    logic        timed_out;
    logic        end_done, end_busy, end_valid;
    logic [47:0] end_subkey;

    localparam logic [55:0] KEY_A = 56'hF0CCAAF556678F;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .pc1_key      (pc1_key),
        .decrypt      (decrypt),
        .start        (start),
        .busy         (busy),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round        (round),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int shift_tab[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int pc2_tab[48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int s);
        logic [55:0] dbl;
        int k;
        k = s % 28;
        dbl = {x, x} << k;
        return dbl[55:28];
    endfunction

    // Textbook schedule: Ci = Ci-1 <<< shift[i], Ki = PC-2(Ci||Di).
    task automatic model_gen(input logic [55:0] key);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] k;
        c = key[55:28];
        d = key[27:0];
        exp_c0 = c;
        exp_d0 = d;
        for (int r = 1; r <= 16; r++) begin
            c  = rotl28(c, shift_tab[r-1]);
            d  = rotl28(d, shift_tab[r-1]);
            cd = {c, d};
            for (int j = 0; j < 48; j++) k[47-j] = cd[56 - pc2_tab[j]];
            exp_keys[r] = k;
        end
    endtask

    // Number of collected entries disagreeing with the model order/rounds.
    function automatic int seq_errors(input logic dec);
        int errs;
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            if (dec) begin
                if (obs_key[i] !== exp_keys[16-i] || obs_round[i] !== 4'(15 - i)) errs++;
            end else begin
                if (obs_key[i] !== exp_keys[i+1] || obs_round[i] !== 4'(i)) errs++;
            end
        end
        return errs;
    endfunction

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic kick(input logic [55:0] key, input logic dec);
        pc1_key = key;
        decrypt = dec;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Collects handshakes. stall_mode: 0 none, 1 five-cycle stall at entry 3
    // plus random, 2 random only. inject_at: pulse a foreign start at that
    // entry (-1 none). abort_at: return once that many were taken (-1 none).
    task automatic collect(input int stall_mode, input int inject_at, input int abort_at);
        logic [47:0] prev_key;
        logic [3:0]  prev_round;
        logic        prev_pending, rdy, stalled3, injected;
        int          stall_left;
        obs_n = 0; stall_bad = 0; done_early = 0; busy_bad = 0; cycles = 0;
        timed_out = 1'b0; prev_pending = 1'b0; stall_left = 0;
        stalled3 = 1'b0; injected = 1'b0; prev_key = '0; prev_round = '0;
        for (int cyc = 0; cyc < 400 && obs_n < 16; cyc++) begin
            if (abort_at >= 0 && obs_n == abort_at) return;
            if (done !== 1'b0) done_early++;
            if (busy !== 1'b1) busy_bad++;
            if (prev_pending && (subkey !== prev_key || round !== prev_round ||
                                 subkey_valid !== 1'b1)) stall_bad++;
            rdy = 1'b1;
            if (stall_mode == 1 && obs_n == 3 && !stalled3) begin
                stalled3   = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if (stall_mode >= 1 && $urandom_range(0, 3) == 0) begin
                rdy = 1'b0;
            end
            start = 1'b0;
            if (inject_at == obs_n && !injected) begin
                injected = 1'b1;
                start    = 1'b1;
                pc1_key  = ~pc1_key;
                decrypt  = ~decrypt;
            end
            subkey_ready = rdy;
            if (subkey_valid === 1'b1) cycles++;
            if (subkey_valid === 1'b1 && rdy) begin
                obs_key[obs_n]   = subkey;
                obs_round[obs_n] = round;
                obs_n++;
                prev_pending = 1'b0;
            end else begin
                prev_pending = (subkey_valid === 1'b1);
            end
            prev_key   = subkey;
            prev_round = round;
            @(negedge clk);
        end
        start = 1'b0;
        if (obs_n < 16) timed_out = 1'b1;
        end_done   = done;
        end_busy   = busy;
        end_valid  = subkey_valid;
        end_subkey = subkey;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b0; pc1_key = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || subkey_valid !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: busy=%b valid=%b done=%b, required all 0", busy, subkey_valid, done);
        end
        tests_run++;
        if (subkey !== 48'h0 || round !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_data: subkey=%h round=%0d, required 0/0", subkey, round);
        end
        rst = 1'b0;
        subkey_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || subkey_valid !== 1'b0 || subkey !== 48'h0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: busy=%b valid=%b subkey=%h, required 0", busy, subkey_valid, subkey);
        end
    endtask

    task automatic test_encrypt();
        model_gen(KEY_A);
        kick(KEY_A, 1'b0);
        tests_run++;
        if (busy !== 1'b1 || subkey_valid !== 1'b1 || round !== 4'd0) begin
            tests_failed++;
            $display("FAIL enc_latency: busy=%b valid=%b round=%0d, required 1/1/0", busy, subkey_valid, round);
        end
        collect(0, -1, -1);
        for (int i = 0; i < 16; i++) enc_obs[i] = obs_key[i];
        tests_run++;
        if (timed_out) begin
            tests_failed++;
            $display("FAIL enc_timeout: got %0d subkeys, required 16", obs_n);
        end
        tests_run++;
        if (obs_key[0] !== 48'h1B02EFFC7072) begin
            tests_failed++;
            $display("FAIL enc_k1: got %h, required 1b02effc7072", obs_key[0]);
        end
        tests_run++;
        if (obs_key[1] !== 48'h79AED9DBC9E5) begin
            tests_failed++;
            $display("FAIL enc_k2: got %h, required 79aed9dbc9e5", obs_key[1]);
        end
        tests_run++;
        if (obs_key[15] !== 48'hCB3D8B0E17F5) begin
            tests_failed++;
            $display("FAIL enc_k16: got %h, required cb3d8b0e17f5", obs_key[15]);
        end
        tests_run++;
        if (seq_errors(1'b0) != 0) begin
            tests_failed++;
            $display("FAIL enc_sequence: %0d entries differ from model, required 0", seq_errors(1'b0));
        end
        tests_run++;
        if (cycles != 16 || done_early != 0 || busy_bad != 0) begin
            tests_failed++;
            $display("FAIL enc_timing: valid_cycles=%0d early_done=%0d busy_low=%0d, required 16/0/0",
                     cycles, done_early, busy_bad);
        end
        tests_run++;
        if (end_done !== 1'b1 || end_busy !== 1'b0 || end_valid !== 1'b0 || end_subkey !== 48'h0) begin
            tests_failed++;
            $display("FAIL enc_end: done=%b busy=%b valid=%b subkey=%h, required 1/0/0/0",
                     end_done, end_busy, end_valid, end_subkey);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_decrypt();
        int rev_errs;
        model_gen(KEY_A);
        kick(KEY_A, 1'b1);
        tests_run++;
        if (subkey !== 48'hCB3D8B0E17F5 || round !== 4'd15) begin
            tests_failed++;
            $display("FAIL dec_first: subkey=%h round=%0d, required cb3d8b0e17f5/15", subkey, round);
        end
        collect(0, -1, -1);
        tests_run++;
        if (timed_out || obs_round[1] !== 4'd14) begin
            tests_failed++;
            $display("FAIL dec_second_round: n=%0d round=%0d, required 16/14", obs_n, obs_round[1]);
        end
        tests_run++;
        if (obs_key[15] !== 48'h1B02EFFC7072 || obs_round[15] !== 4'd0) begin
            tests_failed++;
            $display("FAIL dec_last: subkey=%h round=%0d, required 1b02effc7072/0", obs_key[15], obs_round[15]);
        end
        tests_run++;
        if (seq_errors(1'b1) != 0) begin
            tests_failed++;
            $display("FAIL dec_sequence: %0d entries differ from model, required 0", seq_errors(1'b1));
        end
        rev_errs = 0;
        for (int i = 0; i < 16; i++) if (obs_key[i] !== enc_obs[15-i]) rev_errs++;
        tests_run++;
        if (rev_errs != 0) begin
            tests_failed++;
            $display("FAIL dec_reverse_of_enc: %0d entries differ, required 0", rev_errs);
        end
        tests_run++;
        if (end_done !== 1'b1 || end_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL dec_end: done=%b valid=%b, required 1/0", end_done, end_valid);
        end
    endtask

    task automatic test_backpressure();
        for (int m = 0; m < 2; m++) begin
            model_gen(KEY_A);
            kick(KEY_A, m[0]);
            collect(1, -1, -1);
            tests_run++;
            if (timed_out || seq_errors(m[0]) != 0) begin
                tests_failed++;
                $display("FAIL stall_sequence dec=%0d: n=%0d errors=%0d, required 16/0", m, obs_n, seq_errors(m[0]));
            end
            tests_run++;
            if (stall_bad != 0 || cycles < 21) begin
                tests_failed++;
                $display("FAIL stall_hold dec=%0d: unstable=%0d valid_cycles=%0d, required 0/>=21", m, stall_bad, cycles);
            end
            tests_run++;
            if (end_done !== 1'b1 || done_early != 0) begin
                tests_failed++;
                $display("FAIL stall_done dec=%0d: done=%b early=%0d, required 1/0", m, end_done, done_early);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] r;
        logic [55:0] key_b;
        model_gen(KEY_A);
        kick(KEY_A, 1'b0);
        collect(0, 7, -1);
        tests_run++;
        if (timed_out || seq_errors(1'b0) != 0) begin
            tests_failed++;
            $display("FAIL busy_start_ignored: n=%0d errors=%0d, required 16/0", obs_n, seq_errors(1'b0));
        end
        r = {$urandom, $urandom};
        key_b = r[55:0];
        model_gen(key_b);
        tests_run++;
        if (end_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_cycle_present: done=%b, required 1", end_done);
        end
        kick(key_b, 1'b0);
        tests_run++;
        if (subkey_valid !== 1'b1 || round !== 4'd0 || subkey !== exp_keys[1]) begin
            tests_failed++;
            $display("FAIL start_in_done_cycle: valid=%b round=%0d subkey=%h, required 1/0/%h",
                     subkey_valid, round, subkey, exp_keys[1]);
        end
        collect(2, -1, -1);
        tests_run++;
        if (timed_out || seq_errors(1'b0) != 0) begin
            tests_failed++;
            $display("FAIL back_to_back_sequence: n=%0d errors=%0d, required 16/0", obs_n, seq_errors(1'b0));
        end
    endtask

    task automatic test_mid_reset();
        int done_seen;
        model_gen(KEY_A);
        kick(KEY_A, 1'b0);
        collect(0, -1, 9);
        tests_run++;
        if (obs_n != 9 || round !== 4'd9) begin
            tests_failed++;
            $display("FAIL pre_reset_round: taken=%0d round=%0d, required 9/9", obs_n, round);
        end
        subkey_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || subkey_valid !== 1'b0 || subkey !== 48'h0 || done !== 1'b0 || round !== 4'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: busy=%b valid=%b subkey=%h done=%b round=%0d, required all 0",
                     busy, subkey_valid, subkey, done, round);
        end
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || subkey_valid !== 1'b0) done_seen++;
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++;
            $display("FAIL mid_reset_quiet: %0d cycles with done/valid high, required 0", done_seen);
        end
        kick(KEY_A, 1'b0);
        collect(2, -1, -1);
        tests_run++;
        if (timed_out || seq_errors(1'b0) != 0 || end_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL replay_after_reset: n=%0d errors=%0d done=%b, required 16/0/1",
                     obs_n, seq_errors(1'b0), end_done);
        end
    endtask

    task automatic test_rotation_boundary();
        logic [27:0] exp_c, exp_d;
        logic [27:0] got_c, got_d;
        for (int m = 0; m < 2; m++) begin
            model_gen(56'h80000008000000);
            kick(56'h80000008000000, m[0]);
            collect(0, -1, -1);
            tests_run++;
            if (timed_out || seq_errors(m[0]) != 0) begin
                tests_failed++;
                $display("FAIL boundary_sequence dec=%0d: n=%0d errors=%0d, required 16/0", m, obs_n, seq_errors(m[0]));
            end
            // Loaded state is C1/D1 for encrypt and C0/D0 for decrypt; a full run totals 28.
            exp_c = m[0] ? exp_c0 : rotl28(exp_c0, 1);
            exp_d = m[0] ? exp_d0 : rotl28(exp_d0, 1);
            got_c = dut.c_q;
            got_d = dut.d_q;
            tests_run++;
            if (got_c !== exp_c || got_d !== exp_d) begin
                tests_failed++;
                $display("FAIL boundary_return dec=%0d: c=%h d=%h, required c=%h d=%h", m, got_c, got_d, exp_c, exp_d);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic        dec;
        for (int t = 0; t < 6; t++) begin
            r   = {$urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            model_gen(r[55:0]);
            kick(r[55:0], dec);
            collect(2, -1, -1);
            tests_run++;
            if (timed_out || seq_errors(dec) != 0 || stall_bad != 0 || end_done !== 1'b1) begin
                tests_failed++;
                $display("FAIL random_%0d key=%h dec=%b: n=%0d errors=%0d unstable=%0d done=%b, required 16/0/0/1",
                         t, r[55:0], dec, obs_n, seq_errors(dec), stall_bad, end_done);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_start_while_busy();
        test_mid_reset();
        test_rotation_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
